// File: rtl/simd_pkg.sv
// Function-code constants shared by the SIMD lane's forward activation unit
// and its backward-pass gradient unit.
package simd_pkg;

  localparam logic [3:0] FN_RELU  = 4'b0000;
  localparam logic [3:0] FN_SCALE = 4'b0001;
  localparam logic [3:0] FN_ABS   = 4'b0010;
  localparam logic [3:0] FN_SIGN  = 4'b0011;

  typedef enum logic [1:0] {
    OP_ZERO,
    OP_RELU,
    OP_ABS,
    OP_SCALE
  } grad_op_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Round-half-up arithmetic right shift of a double-width product, saturated
// into a single-width signed result.
module fxp_round_sat #(
  parameter int BIT_WIDTH = 32,
  parameter int SHW       = $clog2(2*BIT_WIDTH)
) (
  input  logic signed [2*BIT_WIDTH-1:0] din,
  input  logic        [SHW-1:0]         shamt,
  output logic signed [BIT_WIDTH-1:0]   dout,
  output logic                          ovf
);
  localparam int PW = 2*BIT_WIDTH;
  localparam logic [BIT_WIDTH-1:0] MAXV = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] MINV = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  // One guard bit keeps the rounding add from wrapping at the widest shift.
  logic signed [PW:0] ext, bias, shifted;

  always_comb begin
    ext  = {din[PW-1], din};
    bias = '0;
    if (shamt != '0) bias = {{PW{1'b0}}, 1'b1} << (shamt - 1'b1);
    shifted = (ext + bias) >>> shamt;
    ovf  = ~((&shifted[PW:BIT_WIDTH-1]) | ~(|shifted[PW:BIT_WIDTH-1]));
    dout = ovf ? (shifted[PW] ? MINV : MAXV) : shifted[BIT_WIDTH-1:0];
  end

endmodule

// File: rtl/calculus_grad_unit.sv
// Per-lane backward-pass unit: dL/dx for ReLU/abs/sign and fixed-point g*x
// scale, as a 3-stage valid/ready pipeline with a single global stall.
module calculus_grad_unit
  import simd_pkg::*;
#(
  parameter int FUNCTION_BITS = 4,
  parameter int BIT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FUNCTION_BITS-1:0]    fn,
  input  logic signed [BIT_WIDTH-1:0] fwd_in,
  input  logic signed [BIT_WIDTH-1:0] grad_in,
  input  logic [7:0]                  dest_integer_bits,
  input  logic [7:0]                  src1_integer_bits,
  input  logic [7:0]                  src2_integer_bits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] data_out,
  output logic                        sat_flag,
  input  logic                        sat_clear
);
  localparam int STAGES = 3;
  localparam int PW     = 2*BIT_WIDTH;
  localparam int SHW    = $clog2(PW);
  localparam logic [BIT_WIDTH-1:0] MAXV = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] MINV = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef struct packed {
    grad_op_e                  op;
    logic signed [BIT_WIDTH-1:0] x;
    logic signed [BIT_WIDTH-1:0] g;
    logic [7:0]                d_int;
    logic [7:0]                s1_int;
    logic [7:0]                s2_int;
  } s1_t;

  typedef struct packed {
    logic                      is_scale;
    logic signed [PW-1:0]      prod;
    logic [SHW-1:0]            shamt;
    logic [BIT_WIDTH-1:0]      res;
    logic                      sat;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;

  logic signed [10:0]          s_raw;
  logic                        pos;
  logic signed [BIT_WIDTH-1:0] rs_out;
  logic                        rs_ovf;
  logic [BIT_WIDTH-1:0]        res3;
  logic                        sat3;

  assign en        = ~vld_pipe[STAGES] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // S1: operand capture and function decode
  always_comb begin
    s1_d        = '0;
    s1_d.x      = fwd_in;
    s1_d.g      = grad_in;
    s1_d.d_int  = dest_integer_bits;
    s1_d.s1_int = src1_integer_bits;
    s1_d.s2_int = src2_integer_bits;
    case (fn)
      FUNCTION_BITS'(FN_RELU):  s1_d.op = OP_RELU;
      FUNCTION_BITS'(FN_ABS):   s1_d.op = OP_ABS;
      FUNCTION_BITS'(FN_SCALE): s1_d.op = OP_SCALE;
      default:                  s1_d.op = OP_ZERO;  // sign' and unknown codes
    endcase
  end

  // S2: product, shift amount, and the select/negate path
  always_comb begin
    s2_d      = '0;
    pos       = ~s1_q.x[BIT_WIDTH-1];
    s_raw     = 11'(BIT_WIDTH) + 11'(s1_q.d_int) - 11'(s1_q.s1_int) - 11'(s1_q.s2_int);
    s2_d.prod = PW'(s1_q.x) * PW'(s1_q.g);
    case (s1_q.op)
      OP_RELU: s2_d.res = pos ? s1_q.g : '0;
      OP_ABS: begin
        if (pos)                 s2_d.res = s1_q.g;
        else if (s1_q.g == MINV) begin
          s2_d.res = MAXV;
          s2_d.sat = 1'b1;
        end else                 s2_d.res = -s1_q.g;
      end
      OP_SCALE: begin
        s2_d.is_scale = 1'b1;
        if (s_raw < 11'sd0) begin
          s2_d.shamt = '0;
          s2_d.sat   = 1'b1;
        end else if (s_raw > $signed(11'(PW-1))) s2_d.shamt = SHW'(PW-1);
        else                                      s2_d.shamt = SHW'(s_raw);
      end
      default: s2_d.res = '0;
    endcase
  end

  // S3: round/shift/saturate for scale, pass-through otherwise
  fxp_round_sat #(.BIT_WIDTH(BIT_WIDTH), .SHW(SHW)) u_round_sat (
    .din   (s2_q.prod),
    .shamt (s2_q.shamt),
    .dout  (rs_out),
    .ovf   (rs_ovf)
  );

  assign res3 = s2_q.is_scale ? rs_out : s2_q.res;
  assign sat3 = s2_q.sat | (s2_q.is_scale & rs_ovf);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      data_out <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (en) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        data_out <= res3;
      end
      // clear beats a same-cycle set
      if (sat_clear)                          sat_flag <= 1'b0;
      else if (en && vld_pipe[2] && sat3)     sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calculus_grad_unit.sv
// Randomized + directed bench for calculus_grad_unit against a wide-integer
// behavioural model with an in-order expected-result queue.
module tb_calculus_grad_unit;
  import simd_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, sat_flag, sat_clear;
  logic [3:0] fn;
  logic signed [W-1:0] fwd_in, grad_in, data_out;
  logic [7:0] dest_integer_bits, src1_integer_bits, src2_integer_bits;

  calculus_grad_unit #(.FUNCTION_BITS(4), .BIT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .fn(fn),
    .fwd_in(fwd_in), .grad_in(grad_in), .dest_integer_bits(dest_integer_bits),
    .src1_integer_bits(src1_integer_bits), .src2_integer_bits(src2_integer_bits),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .sat_flag(sat_flag), .sat_clear(sat_clear)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; bit sat; int cyc; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0, ncyc = 0;
  bit   model_sat = 0, lat_chk = 0, done = 0;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_grad(logic [3:0] f, logic signed [W-1:0] x, logic signed [W-1:0] g,
                                    logic [7:0] di, logic [7:0] a, logic [7:0] b);
    exp_t e;
    logic signed [127:0] p, pg;
    int s;
    e.d = '0; e.sat = 0; e.cyc = 0;
    if (f == FN_RELU) e.d = (x >= 0) ? g : '0;
    else if (f == FN_ABS) begin
      if (x >= 0) e.d = g;
      else if (g == MINV) begin e.d = MAXV; e.sat = 1; end
      else e.d = -g;
    end else if (f == FN_SCALE) begin
      s = W - int'(a) - int'(b) + int'(di);
      if (s < 0) begin s = 0; e.sat = 1; end
      if (s > 2*W-1) s = 2*W-1;
      p = x; pg = g; p = p * pg;
      if (s > 0) p = p + (128'sd1 <<< (s-1));
      p = p >>> s;
      if (p > 128'sd2147483647)       begin e.d = MAXV; e.sat = 1; end
      else if (p < -128'sd2147483648) begin e.d = MINV; e.sat = 1; end
      else e.d = p[W-1:0];
    end
    return e;
  endfunction

  // Monitor: mid-cycle sampling of both handshakes
  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      q.delete();
      model_sat = 0;
    end else begin
      if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          mon_e = q.pop_front();
          model_sat |= mon_e.sat;
          chk("data", data_out, mon_e.d);
          chk("sat_flag", 32'(sat_flag), 32'(model_sat));
          if (lat_chk) chk("latency", 32'(ncyc - mon_e.cyc), 32'd3);
        end
      end
      if (sat_clear) model_sat = 0;
      if (in_valid && in_ready) begin
        mon_e = ref_grad(fn, fwd_in, grad_in, dest_integer_bits, src1_integer_bits, src2_integer_bits);
        mon_e.cyc = ncyc;
        q.push_back(mon_e);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [3:0] f, logic [W-1:0] x, logic [W-1:0] g,
                      logic [7:0] di = 8'd16, logic [7:0] a = 8'd16, logic [7:0] b = 8'd16);
    bit acc;
    int t;
    t = 0;
    fn = f; fwd_in = x; grad_in = g;
    dest_integer_bits = di; src1_integer_bits = a; src2_integer_bits = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(string tag, logic [W-1:0] v);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin chk(tag, data_out, v); return; end
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return MINV;
      2: return MAXV;
      3: return W'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick_int();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 48)) : 8'd16;
  endfunction

  initial begin
    reset = 1; in_valid = 0; out_ready = 1; sat_clear = 0;
    fn = '0; fwd_in = '0; grad_in = '0;
    dest_integer_bits = 16; src1_integer_bits = 16; src2_integer_bits = 16;
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    @(posedge clk); #1 reset = 0;
    lat_chk = 1;

    send(FN_RELU, -32'sd5, 32'd100);
    send(FN_RELU, 32'd7, 32'd100);
    send(FN_RELU, 32'd0, 32'd100);
    idle(6);
    chk("relu_sat", 32'(sat_flag), 32'd0);

    send(FN_ABS, -32'sd3, 32'd100);
    expect_out("abs_neg", -32'sd100);
    send(FN_ABS, -32'sd3, MINV);
    expect_out("abs_min", MAXV);
    chk("abs_sat", 32'(sat_flag), 32'd1);
    idle(3);
    sat_clear = 1; idle(1); sat_clear = 0;
    @(negedge clk);
    chk("sat_clear", 32'(sat_flag), 32'd0);

    idle(1);
    send(FN_SCALE, 32'h0002_0000, 32'h0001_8000);
    expect_out("scale", 32'h0003_0000);
    send(FN_SCALE, 32'h7FFF_0000, 32'h7FFF_0000);
    expect_out("scale_sat", MAXV);
    chk("scale_sat_flag", 32'(sat_flag), 32'd1);
    idle(3);
    sat_clear = 1; idle(1); sat_clear = 0;

    send(4'b0101, 32'd9, 32'd9);
    expect_out("fn_unknown", 32'd0);
    send(FN_SIGN, 32'd9, 32'd9);
    expect_out("fn_sign", 32'd0);
    chk("fn_zero_sat", 32'(sat_flag), 32'd0);
    idle(3);

    // backpressure: out_ready low for 4 cycles while 6 elements stream
    lat_chk = 0;
    fork
      begin for (int i = 1; i <= 6; i++) send(FN_RELU, 32'd1, W'(i)); end
      begin idle(3); out_ready = 0; idle(4); out_ready = 1; end
    join
    drain();

    // reset with three elements in flight
    lat_chk = 1;
    send(FN_RELU, 32'd1, 32'd11);
    send(FN_RELU, 32'd1, 32'd12);
    send(FN_RELU, 32'd1, 32'd13);
    reset = 1; idle(1); reset = 0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", data_out, 32'd0);
    idle(1);
    send(FN_RELU, 32'd1, 32'd77);
    expect_out("post_rst", 32'd77);
    idle(3);

    // randomized traffic with random backpressure
    lat_chk = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [3:0] f;
          f = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
          if ($urandom_range(0, 3) == 0) idle(1);
          send(f, pick(), pick(), pick_int(), pick_int(), pick_int());
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
